// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO/UART controller: register offsets,
// status bit positions and the TX holding-register state type.
package mmio_pkg;

  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RXDATA  = 8'h04;
  localparam logic [7:0] OFF_TXDATA  = 8'h08;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_INSTRET = 8'h14;
  localparam logic [7:0] OFF_CNTRST  = 8'h18;

  localparam int STAT_TX_EMPTY_BIT    = 0;
  localparam int STAT_RX_NONEMPTY_BIT = 1;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/mmio_rx_fifo.sv
// Small circular byte FIFO buffering UART receive data until software pops it.
// Push is ignored when full and pop is ignored when empty.
module mmio_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO page controller: decodes core loads/stores into UART RX FIFO pops,
// TX holding-register writes, status reads and cycle/instret counters.
module uart_mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wbe,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  tx_state_e   tx_state_q, tx_state_d;
  logic [7:0]  tx_byte_q,  tx_byte_d;
  logic [31:0] rdata_q,    rdata_d;
  logic [31:0] cycle_q,    cycle_d;
  logic [31:0] instret_q,  instret_d;

  logic        ld, st, tx_wr, cnt_clr, rx_pop;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign ld      = req_valid && !req_we;
  assign st      = req_valid &&  req_we;
  assign tx_wr   = st && (req_addr == OFF_TXDATA) && req_wbe[0];
  assign cnt_clr = st && (req_addr == OFF_CNTRST);
  assign rx_pop  = ld && (req_addr == OFF_RXDATA);

  assign unused_bits = ^{req_wdata[31:8], req_wbe[3:1]};

  mmio_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .wdata (rx_data),
    .pop   (rx_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign rx_ready = !fifo_full;
  assign tx_valid = (tx_state_q == TX_FULL);
  assign tx_data  = tx_byte_q;
  assign rdata    = rdata_q;

  // A store landing in the same cycle as the transmit handshake is dropped:
  // software saw the register as full when it issued the store.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_byte_d  = tx_byte_q;
    case (tx_state_q)
      TX_EMPTY: begin
        if (tx_wr) begin
          tx_state_d = TX_FULL;
          tx_byte_d  = req_wdata[7:0];
        end
      end
      TX_FULL: begin
        if (tx_ready) tx_state_d = TX_EMPTY;
      end
      default: tx_state_d = TX_EMPTY;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (req_addr)
      OFF_STATUS: begin
        rd_val[STAT_TX_EMPTY_BIT]    = (tx_state_q == TX_EMPTY);
        rd_val[STAT_RX_NONEMPTY_BIT] = !fifo_empty;
      end
      OFF_RXDATA:  rd_val = fifo_empty ? 32'd0 : {24'd0, fifo_head};
      OFF_CYCLE:   rd_val = cycle_q;
      OFF_INSTRET: rd_val = instret_q;
      default:     rd_val = '0;
    endcase
    rdata_d = ld ? rd_val : rdata_q;
  end

  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    instret_d = inst_retire ? instret_q + 32'd1 : instret_q;
    if (cnt_clr) begin
      cycle_d   = '0;
      instret_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_EMPTY;
      tx_byte_q  <= '0;
      rdata_q    <= '0;
      cycle_q    <= '0;
      instret_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_byte_q  <= tx_byte_d;
      rdata_q    <= rdata_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
    end
  end

endmodule
